// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALUCtrl encoding shared by the arbiter, alu_control and the ALU
package alu_arbiter_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_BNE = 4'd9
    } aluCtrl_e;

    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MAX = 4'd9;

    function automatic logic isLegalCtrl(input logic [ALU_CTRL_W-1:0] code);
        return code <= ALU_CTRL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester bundle, ALU drive/return and response slot of the shared ALU
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int XLEN = 32
);
    import alu_arbiter_pkg::*;

    logic [NREQ-1:0]            req_valid_i;
    logic [NREQ-1:0]            req_ready_o;
    logic [NREQ*ALU_CTRL_W-1:0] req_ctrl_i;
    logic [NREQ*XLEN-1:0]       req_a_i;
    logic [NREQ*XLEN-1:0]       req_b_i;
    logic [ALU_CTRL_W-1:0]      alu_ctrl_o;
    logic [XLEN-1:0]            alu_a_o;
    logic [XLEN-1:0]            alu_b_o;
    logic [XLEN-1:0]            alu_res_i;
    logic                       rsp_valid_o;
    logic [IDW-1:0]             rsp_id_o;
    logic [XLEN-1:0]            rsp_data_o;
    logic                       rsp_zero_o;
    logic [NREQ-1:0]            rsp_ready_i;
    logic                       err_o;

    // requesters plus the combinational ALU
    modport master (
        output req_valid_i, req_ctrl_i, req_a_i, req_b_i, alu_res_i, rsp_ready_i,
        input  req_ready_o, alu_ctrl_o, alu_a_o, alu_b_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, err_o
    );

    // the arbiter itself
    modport slave (
        input  req_valid_i, req_ctrl_i, req_a_i, req_b_i, alu_res_i, rsp_ready_i,
        output req_ready_o, alu_ctrl_o, alu_a_o, alu_b_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, err_o
    );

endinterface

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr with wrap
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    // first set request at or after ptr wins; gnt is the one-hot form of idx
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
        gnt = found ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with a single registered response slot
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int XLEN = 32
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_arbiter_if.slave bus
);

    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        gntIdx;
    logic [NREQ-1:0]       gntVec;
    logic                  gntFound;
    logic                  slotFree;
    logic                  accept;
    logic                  illegal;
    logic [ALU_CTRL_W-1:0] selCtrl;
    logic [XLEN-1:0]       selA;
    logic [XLEN-1:0]       selB;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (bus.req_valid_i),
        .ptr   (ptr),
        .gnt   (gntVec),
        .idx   (gntIdx),
        .found (gntFound)
    );

    // only the owner's ready can free the slot; a stalled slot blocks every new grant
    assign slotFree = !bus.rsp_valid_o || bus.rsp_ready_i[bus.rsp_id_o];
    assign accept   = gntFound && slotFree;

    // steer the granted requester onto the ALU, neutralising illegal codes to ADD
    always_comb begin
        selCtrl         = bus.req_ctrl_i[int'(gntIdx)*ALU_CTRL_W +: ALU_CTRL_W];
        selA            = bus.req_a_i[int'(gntIdx)*XLEN +: XLEN];
        selB            = bus.req_b_i[int'(gntIdx)*XLEN +: XLEN];
        illegal         = gntFound && !isLegalCtrl(selCtrl);
        bus.alu_ctrl_o  = (gntFound && !illegal) ? selCtrl : ALU_ADD;
        bus.alu_a_o     = gntFound ? selA : '0;
        bus.alu_b_o     = gntFound ? selB : '0;
        bus.req_ready_o = accept ? gntVec : '0;
    end

    // response slot, round-robin pointer and sticky illegal-code flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr             <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_id_o    <= '0;
            bus.rsp_data_o  <= '0;
            bus.rsp_zero_o  <= 1'b0;
            bus.err_o       <= 1'b0;
        end else if (accept) begin
            ptr             <= (gntIdx == IDW'(NREQ-1)) ? '0 : gntIdx + 1'b1;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_id_o    <= gntIdx;
            bus.rsp_data_o  <= bus.alu_res_i;
            bus.rsp_zero_o  <= (bus.alu_res_i == '0);
            bus.err_o       <= bus.err_o || illegal;
        end else if (slotFree) begin
            bus.rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a response scoreboard drained by an independent monitor
module tb_alu_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        zero;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    int   tests = 0;
    int   errors = 0;
    rsp_t sb[$];
    rsp_t exp;

    logic [3:0]  c0 = '0, c1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(2), .IDW(1), .XLEN(32)) bus ();

    alu_arbiter #(.NREQ(2), .IDW(1), .XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // reference ALU driven by whatever the arbiter presents
    always_comb begin
        case (bus.alu_ctrl_o)
            4'd0:    bus.alu_res_i = bus.alu_a_o + bus.alu_b_o;
            4'd1:    bus.alu_res_i = bus.alu_a_o - bus.alu_b_o;
            4'd2:    bus.alu_res_i = bus.alu_a_o & bus.alu_b_o;
            4'd3:    bus.alu_res_i = bus.alu_a_o | bus.alu_b_o;
            4'd4:    bus.alu_res_i = {31'd0, $signed(bus.alu_a_o) < $signed(bus.alu_b_o)};
            4'd5:    bus.alu_res_i = bus.alu_a_o ^ bus.alu_b_o;
            4'd6:    bus.alu_res_i = bus.alu_a_o << bus.alu_b_o[4:0];
            4'd7:    bus.alu_res_i = bus.alu_a_o >> bus.alu_b_o[4:0];
            4'd8:    bus.alu_res_i = $unsigned($signed(bus.alu_a_o) >>> bus.alu_b_o[4:0]);
            4'd9:    bus.alu_res_i = bus.alu_a_o - bus.alu_b_o;
            default: bus.alu_res_i = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // apply one cycle of requests, check the grant, and queue the expected response
    task automatic drive(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] rdy,
                         input logic id, input logic [31:0] data, input logic zero);
        rsp_t e;
        bus.req_ctrl_i  = {c1, c0};
        bus.req_a_i     = {a1, a0};
        bus.req_b_i     = {b1, b0};
        bus.req_valid_i = v;
        bus.rsp_ready_i = rr;
        #1;
        chk("req_ready", 32'(bus.req_ready_o), 32'(rdy));
        if (rdy != 2'b00) begin
            e.id = id;
            e.data = data;
            e.zero = zero;
            sb.push_back(e);
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] rdy,
                       input logic id, input logic [31:0] data, input logic zero);
        tick();
        drive(v, rr, rdy, id, data, zero);
    endtask

    // monitor: every consumed response must match the oldest queued expectation
    always @(negedge clk) begin
        if (started && !rst && bus.rsp_valid_o && bus.rsp_ready_i[bus.rsp_id_o]) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response",
                         bus.rsp_id_o, bus.rsp_data_o);
            end else begin
                exp = sb.pop_front();
                chk("rsp_id", 32'(bus.rsp_id_o), 32'(exp.id));
                chk("rsp_data", bus.rsp_data_o, exp.data);
                chk("rsp_zero", 32'(bus.rsp_zero_o), 32'(exp.zero));
            end
        end
    end

    initial begin
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        bus.req_ctrl_i  = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_id", 32'(bus.rsp_id_o), 0);
        chk("rst_data", bus.rsp_data_o, 0);
        chk("rst_zero", 32'(bus.rsp_zero_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        rst = 1'b0;
        started = 1'b1;
        cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);
        chk("idle_ctrl", 32'(bus.alu_ctrl_o), 0);
        chk("idle_a", bus.alu_a_o, 0);
        chk("idle_b", bus.alu_b_o, 0);
        chk("idle_valid", 32'(bus.rsp_valid_o), 0);

        // single ADD from requester 0
        c0 = 4'd0; a0 = 32'd5; b0 = 32'd7;
        cyc(2'b01, 2'b11, 2'b01, 0, 32'd12, 0);
        chk("add_a", bus.alu_a_o, 32'd5);
        cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);

        // both valid: pointer sits at 1 after the previous grant, so 1,0,1,0
        c0 = 4'd1; a0 = 32'd20; b0 = 32'd3;
        c1 = 4'd2; a1 = 32'hF0; b1 = 32'h3C;
        cyc(2'b11, 2'b11, 2'b10, 1, 32'h30, 0);
        cyc(2'b11, 2'b11, 2'b01, 0, 32'd17, 0);
        cyc(2'b11, 2'b11, 2'b10, 1, 32'h30, 0);
        cyc(2'b11, 2'b11, 2'b01, 0, 32'd17, 0);

        // zero-result op from requester 1, then a stall on its response
        c1 = 4'd5; a1 = 32'd9; b1 = 32'd9;
        cyc(2'b10, 2'b11, 2'b10, 1, 32'd0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
            chk("stall_valid", 32'(bus.rsp_valid_o), 1);
            chk("stall_id", 32'(bus.rsp_id_o), 1);
            chk("stall_data", bus.rsp_data_o, 0);
            chk("stall_zero", 32'(bus.rsp_zero_o), 1);
        end
        cyc(2'b11, 2'b01, 2'b00, 0, 0, 0);
        chk("wrong_rdy_valid", 32'(bus.rsp_valid_o), 1);
        chk("wrong_rdy_id", 32'(bus.rsp_id_o), 1);
        cyc(2'b11, 2'b10, 2'b01, 0, 32'd17, 0);
        cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);

        // illegal code executes as ADD and raises the sticky error
        c0 = 4'd12; a0 = 32'd3; b0 = 32'd4;
        cyc(2'b01, 2'b11, 2'b01, 0, 32'd7, 0);
        chk("illegal_ctrl", 32'(bus.alu_ctrl_o), 0);
        chk("err_before", 32'(bus.err_o), 0);
        for (int i = 1; i <= 10; i++) begin
            c0 = 4'd0; a0 = 32'(i); b0 = 32'd1;
            cyc(2'b01, 2'b11, 2'b01, 0, 32'(i + 1), 0);
            chk("err_sticky", 32'(bus.err_o), 1);
        end
        cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);

        // reset over a stalled response with both requests pending; pointer left at 1 beforehand
        a0 = 32'd50; b0 = 32'd50;
        c1 = 4'd2; a1 = 32'hF0; b1 = 32'h3C;
        cyc(2'b01, 2'b00, 2'b01, 0, 32'd100, 0);
        cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
        chk("pre_rst_valid", 32'(bus.rsp_valid_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_valid", 32'(bus.rsp_valid_o), 0);
        chk("post_rst_err", 32'(bus.err_o), 0);
        sb.delete();
        a0 = 32'd100; b0 = 32'd23;
        drive(2'b11, 2'b11, 2'b01, 0, 32'd123, 0);
        cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);
        tick();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
